// File: rtl/bus_source_arbiter_if.sv
// Bus-source arbitration interface.
//   master : control unit side   - drives req, observes grant/select/status
//   slave  : arbiter side        - observes req, drives grant/select/status
// Signals:
//   req          per-source bus request (bit k requests source data_k)
//   select       5-bit multiplexer select code, 0 = idle
//   grant        one-hot current owner, zero when idle
//   busy         grant is non-zero
//   bus_valid    mux output currently holds the owner's data
//   hold_expired one-cycle pulse after a hold-limit revoke
`timescale 1ns/1ps
interface bus_source_arbiter_if #(
    parameter int unsigned NUM_SRC = 25
);
    logic [NUM_SRC-1:0] req;
    logic [4:0]         select;
    logic [NUM_SRC-1:0] grant;
    logic               busy;
    logic               bus_valid;
    logic               hold_expired;

    modport master (
        output req,
        input  select, grant, busy, bus_valid, hold_expired
    );

    modport slave (
        input  req,
        output select, grant, busy, bus_valid, hold_expired
    );
endinterface

// File: rtl/bus_source_arbiter.sv
// Round-robin bus source arbiter driving the 32-to-1 datapath multiplexer.
// Ownership is held while the owner keeps requesting; an optional hold limit
// revokes an owner that has held for HOLD_MAX cycles while others wait.
// Ports:
//   clk      system clock, rising edge
//   clear_n  asynchronous active-low reset
//   bus      bus_source_arbiter_if.slave (req in; select/grant/busy/
//            bus_valid/hold_expired out)
`timescale 1ns/1ps
module bus_source_arbiter #(
    parameter int unsigned NUM_SRC  = 25,
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic                  clk,
    input  logic                  clear_n,
    bus_source_arbiter_if.slave   bus
);
    localparam int unsigned IdxW = 5;
    localparam int unsigned CntW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

    typedef enum logic [0:0] {StIdle, StOwn} state_e;

    state_e             state_q;
    logic [NUM_SRC-1:0] grant_q;
    logic [IdxW-1:0]    last_q;
    logic [CntW-1:0]    hold_cnt_q;
    logic [4:0]         select_q;
    logic               bus_valid_q;
    logic               hold_expired_q;

    logic [NUM_SRC-1:0] cand;
    logic [IdxW-1:0]    win_idx;
    logic               win_found;
    logic               owner_req;
    logic               limit_hit;

    // Mux code for a source index; codes 26-31 are unreachable.
    function automatic logic [4:0] code_of(input logic [IdxW-1:0] k);
        logic [4:0] c;
        case (k)
            5'd0:    c = 5'd1;
            5'd1:    c = 5'd3;
            5'd2:    c = 5'd2;
            default: c = k + 5'd1;
        endcase
        return c;
    endfunction

    // The owner is always last_q and is masked out of the candidate set, so a
    // single search from last_q+1 serves IDLE, release and revoke alike.
    always_comb begin
        int              idx;
        logic [IdxW-1:0] idx5;
        cand      = bus.req & ~grant_q;
        win_idx   = '0;
        win_found = 1'b0;
        // Walk backwards so the nearest set bit after last_q is written last.
        for (int i = int'(NUM_SRC); i >= 1; i--) begin
            idx  = (int'(last_q) + i) % int'(NUM_SRC);
            idx5 = IdxW'(idx);
            if (cand[idx5]) begin
                win_idx   = idx5;
                win_found = 1'b1;
            end
        end
        owner_req = |(bus.req & grant_q);
        // hold_cnt_q counts completed hold edges, so +1 is cycles held so far.
        limit_hit = (HOLD_MAX != 0) && ((32'(hold_cnt_q) + 32'd1) >= HOLD_MAX) && (|cand);
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q        <= StIdle;
            grant_q        <= '0;
            last_q         <= IdxW'(NUM_SRC - 1);
            hold_cnt_q     <= '0;
            select_q       <= '0;
            bus_valid_q    <= 1'b0;
            hold_expired_q <= 1'b0;
        end else begin
            hold_expired_q <= 1'b0;
            if (state_q == StOwn && owner_req && !limit_hit) begin
                // Owner keeps the bus; mux now reflects it.
                bus_valid_q <= 1'b1;
                if (32'(hold_cnt_q) < HOLD_MAX) begin
                    hold_cnt_q <= hold_cnt_q + 1'b1;
                end
            end else if (win_found) begin
                // New grant from idle, handoff on release, or revoke.
                state_q        <= StOwn;
                grant_q        <= NUM_SRC'(1) << win_idx;
                select_q       <= code_of(win_idx);
                last_q         <= win_idx;
                hold_cnt_q     <= '0;
                bus_valid_q    <= 1'b0;
                hold_expired_q <= (state_q == StOwn) && owner_req;
            end else begin
                state_q     <= StIdle;
                grant_q     <= '0;
                select_q    <= '0;
                bus_valid_q <= 1'b0;
            end
        end
    end

    assign bus.grant        = grant_q;
    assign bus.select       = select_q;
    assign bus.busy         = |grant_q;
    assign bus.bus_valid    = bus_valid_q;
    assign bus.hold_expired = hold_expired_q;

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Self-checking bench for bus_source_arbiter: a cycle-level reference model
// pushes expected outputs into a scoreboard queue at each rising edge and a
// monitor pops and compares them shortly after the edge.
`timescale 1ns/1ps
module tb_bus_source_arbiter;
    localparam int NS   = 25;
    localparam int HOLD = 16;

    logic clk;
    logic clear_n;

    bus_source_arbiter_if #(.NUM_SRC(NS)) bus ();

    bus_source_arbiter #(
        .NUM_SRC  (NS),
        .HOLD_MAX (HOLD)
    ) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NS-1:0] grant;
        logic [4:0]    sel;
        logic          busy;
        logic          valid;
        logic          hexp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_owner  = -1;   // -1 = idle
    int m_last   = NS - 1;
    int m_cycles = 0;    // grant cycles spent by the current owner
    bit m_valid  = 0;
    bit m_hexp   = 0;

    function automatic int code_of(input int k);
        if (k == 0) return 1;
        if (k == 1) return 3;
        if (k == 2) return 2;
        return k + 1;
    endfunction

    function automatic int rr_pick(input logic [NS-1:0] r, input int start);
        for (int i = 1; i <= NS; i++) begin
            int k;
            k = (start + i) % NS;
            if (r[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner  = -1;
        m_last   = NS - 1;
        m_cycles = 0;
        m_valid  = 0;
        m_hexp   = 0;
    endtask

    initial forever begin
        @(negedge clear_n);
        model_reset();
    end

    initial forever begin
        logic [NS-1:0] r;
        logic [NS-1:0] others;
        int            w;
        bit            own_r;
        bit            over;
        exp_t          e;
        @(posedge clk);
        r = bus.req;
        if (!clear_n) begin
            model_reset();
        end else if (m_owner < 0) begin
            w       = rr_pick(r, m_last);
            m_valid = 0;
            m_hexp  = 0;
            if (w >= 0) begin
                m_owner  = w;
                m_last   = w;
                m_cycles = 1;
            end
        end else begin
            others = r & ~(NS'(1) << m_owner);
            own_r  = r[m_owner];
            over   = (HOLD > 0) && (m_cycles >= HOLD) && (others != 0);
            if (own_r && !over) begin
                m_cycles++;
                m_valid = 1;
                m_hexp  = 0;
            end else begin
                w       = rr_pick(others, m_owner);
                m_valid = 0;
                m_hexp  = (w >= 0) && own_r;
                if (w >= 0) begin
                    m_owner  = w;
                    m_last   = w;
                    m_cycles = 1;
                end else begin
                    m_owner = -1;
                end
            end
        end
        e.grant = (m_owner >= 0) ? (NS'(1) << m_owner) : '0;
        e.sel   = (m_owner >= 0) ? 5'(code_of(m_owner)) : 5'd0;
        e.busy  = (m_owner >= 0);
        e.valid = m_valid;
        e.hexp  = m_hexp;
        sb.push_back(e);
    end

    // ---------------- monitor ----------------
    initial forever begin
        exp_t e;
        @(posedge clk);
        #2;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("sb_grant", 32'(bus.grant), 32'(e.grant));
            chk("sb_select", 32'(bus.select), 32'(e.sel));
            chk("sb_busy", 32'(bus.busy), 32'(e.busy));
            chk("sb_bus_valid", 32'(bus.bus_valid), 32'(e.valid));
            chk("sb_hold_expired", 32'(bus.hold_expired), 32'(e.hexp));
            chk("grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_req(input logic [NS-1:0] v);
        @(negedge clk);
        bus.req = v;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        clear_n = 1'b0;
        bus.req = '0;
        repeat (2) @(negedge clk);
        clear_n = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, 32'(bus.grant), 32'd0);
        chk({tag, "_select"}, 32'(bus.select), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_bus_valid"}, 32'(bus.bus_valid), 32'd0);
        chk({tag, "_hold_expired"}, 32'(bus.hold_expired), 32'd0);
    endtask

    initial begin
        int            ord[6];
        int            cnt5;
        int            pulses;
        int            lost;
        int            pool[5];
        logic [NS-1:0] m;
        logic [NS-1:0] r;

        clear_n = 1'b0;
        bus.req = '0;

        // Reset state, then first grant and bus_valid latency.
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        bus.req = NS'(1);
        clear_n = 1'b1;
        @(posedge clk); #2;
        chk("first_grant", 32'(bus.grant), 32'h0000001);
        chk("first_select", 32'(bus.select), 32'd1);
        chk("first_bus_valid", 32'(bus.bus_valid), 32'd0);
        @(posedge clk); #2;
        chk("first_bus_valid_rise", 32'(bus.bus_valid), 32'd1);
        set_req('0);
        idle_cycles(2);

        // Code map sweep.
        for (int k = 0; k < NS; k++) begin
            set_req(NS'(1) << k);
            @(posedge clk); #2;
            chk("sweep_select", 32'(bus.select), 32'(code_of(k)));
            set_req('0);
            idle_cycles(1);
        end

        // Rotation among 3, 7, 20 with each owner releasing after 2 cycles.
        reset_dut();
        ord[0] = 3; ord[1] = 7; ord[2] = 20; ord[3] = 3; ord[4] = 7; ord[5] = 20;
        m = (NS'(1) << 3) | (NS'(1) << 7) | (NS'(1) << 20);
        set_req(m);
        for (int j = 0; j < 6; j++) begin
            @(posedge clk); #2;
            chk("rot_grant", 32'(bus.grant), 32'(NS'(1) << ord[j]));
            chk("rot_busy", 32'(bus.busy), 32'd1);
            set_req(m);
            set_req(m & ~(NS'(1) << ord[j]));
        end
        set_req('0);
        idle_cycles(2);

        // Hold limit: 5 owns, 6 waits from the start.
        reset_dut();
        set_req((NS'(1) << 5) | (NS'(1) << 6));
        cnt5   = 0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #2;
            if (bus.grant == (NS'(1) << 5)) cnt5++;
            if (bus.hold_expired) pulses++;
        end
        chk("hold_cycles_src5", 32'(cnt5), 32'(HOLD));
        chk("hold_expired_pulses", 32'(pulses), 32'd1);
        chk("hold_new_select", 32'(bus.select), 32'd7);
        set_req('0);
        idle_cycles(2);

        // Lone requester is never revoked.
        reset_dut();
        set_req(NS'(1) << 5);
        pulses = 0;
        lost   = 0;
        repeat (100) begin
            @(posedge clk); #2;
            if (bus.hold_expired) pulses++;
            if (bus.grant != (NS'(1) << 5)) lost++;
        end
        chk("lone_no_revoke", 32'(pulses), 32'd0);
        chk("lone_kept_grant", 32'(lost), 32'd0);
        set_req('0);
        idle_cycles(2);

        // Wrap-around from last = 24.
        reset_dut();
        set_req((NS'(1) << 24) | NS'(1));
        @(posedge clk); #2;
        chk("wrap_grant0", 32'(bus.grant), 32'd1);
        set_req(NS'(1) << 24);
        @(posedge clk); #2;
        chk("wrap_grant24", 32'(bus.grant), 32'(NS'(1) << 24));
        chk("wrap_select25", 32'(bus.select), 32'd25);

        // Asynchronous reset mid-grant, then source 10 held through reset.
        @(posedge clk); #3;
        clear_n = 1'b0;
        bus.req = NS'(1) << 10;
        #1;
        chk_all_zero("async");
        @(negedge clk);
        clear_n = 1'b1;
        @(posedge clk); #2;
        chk("post_reset_grant10", 32'(bus.grant), 32'(NS'(1) << 10));
        chk("post_reset_select11", 32'(bus.select), 32'd11);
        set_req('0);
        idle_cycles(2);

        // Randomized contention among a small pool of sources.
        reset_dut();
        pool[0] = 0; pool[1] = 2; pool[2] = 11; pool[3] = 23; pool[4] = 24;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 11) == 0) begin
                r = '0;
                for (int p = 0; p < 5; p++) begin
                    if ($urandom_range(0, 1) == 1) r[pool[p]] = 1'b1;
                end
                bus.req = r;
            end
        end
        set_req('0);
        idle_cycles(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_source_arbiter.md
# bus_source_arbiter

Drive side of the datapath bus: takes up to 25 source requests from the control unit, grants exactly one, and produces the 5-bit `select` code consumed by the 32-to-1 bus multiplexer. Arbitration is round-robin with ownership held while the owner keeps requesting, plus an optional hold limit that enforces fairness. Because the multiplexer registers its output, the block also reports when the bus contents actually reflect the current owner.

## Interface
- `NUM_SRC`, 25: number of requesters; the code map below is defined for exactly 25.
- `HOLD_MAX`, 16: maximum consecutive grant cycles while another source is waiting; 0 disables the limit.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `clear_n`  input  1  reset, asynchronous, active-low.
- `req`  input  25  per-source bus request; bit k requests source `data_k`.
- `select`  output  5  multiplexer select code; 0 = idle (mux default value).
- `grant`  output  25  one-hot current owner; all zero when idle.
- `busy`  output  1  high whenever `grant` is non-zero.
- `bus_valid`  output  1  high when multiplexer output holds the current owner's data.
- `hold_expired`  output  1  one-cycle pulse when ownership was revoked by `HOLD_MAX`.

## Operation
- Code map, source k -> `select`: 0->1, 1->3, 2->2, k>=3 -> k+1 (source 24 -> 25). Idle -> 0. Codes 26-31 are never produced.
- States: IDLE (`grant`=0, `select`=0) and OWN (one grant bit set).
- Pointer `last` (0..24) holds the most recently granted index and resets to 24, so the first search starts at source 0.
- Search order: `last`+1, `last`+2, ... wrapping 24->0, ending at `last`. The first set `req` bit in that order wins.
- IDLE: if any `req` is set, the next edge grants the winner, enters OWN, sets `last` to the winner, and clears `hold_cnt`. Otherwise the block stays in IDLE.
- OWN, owner's `req` still high and no limit reached: hold the grant; `hold_cnt` increments, saturating at `HOLD_MAX`.
- OWN, owner's `req` low: on the same edge, re-arbitrate with the search starting at owner+1. If a winner exists, hand off directly with no idle cycle. If none, go to IDLE.
- Hold limit (`HOLD_MAX`>0): an owner that has held for `HOLD_MAX` cycles while at least one other `req` is set is revoked on the next edge. The grant passes to the next round-robin winner, excluding the owner, and `hold_expired` pulses for one cycle.
  - A lone requester is never revoked.
  - A revoked source competes again normally afterwards.
- Multiple simultaneous requests: exactly one grant is issued. `grant` is always zero-hot or one-hot.
- Requests for non-owners may rise and fall freely. They are sampled only at arbitration edges.

## Timing
- Reset (`clear_n` low, asynchronous, including mid-grant): `select`=0, `grant`=0, `busy`=0, `bus_valid`=0, `hold_expired`=0, `last`=24, `hold_cnt`=0. The first grant is possible on the first rising edge after `clear_n` rises.
- Grant latency: `req` sampled high on edge N means `grant`/`select`/`busy` update after edge N.
- `bus_valid`: the multiplexer samples `select` on edge N+1, so `bus_valid` rises after edge N+1. It stays high while the owner is unchanged.
- On any owner change (handoff, revoke, or release to IDLE), `bus_valid` falls on the same edge that `select` changes. On a handoff it rises again one edge later.
- Release: the owner's `req` low at edge M means the new `grant` (or idle) takes effect after edge M. The release costs one cycle, with no extra gap.
- `hold_expired` is registered and high for exactly the cycle following the revoking edge.

## Test plan
- Reset then `req`=bit 0 only -> after edge 1: `grant`=0x0000001, `select`=1, `bus_valid`=0. After edge 2: `bus_valid`=1.
- Code map sweep: request each source k alone, then release -> `select` sequence 1,3,2,4,5,...,25, returning to 0 between requests. `grant` stays one-hot throughout.
- `req` bits 3, 7 and 20 held constantly with each owner releasing after 2 cycles -> grants rotate 3,7,20,3,7,20 with no idle cycles and `select` values 4,8,21.
- `HOLD_MAX`=16: source 5 holds and source 6 requests from the start -> source 5 is revoked after 16 grant cycles, `grant` moves to 6 (`select`=7), and `hold_expired` pulses once. With source 5 alone there is no revoke for 100 cycles.
- Wrap-around: `last`=24 with `req` bits 24 and 0 -> bit 0 wins. Releasing 0 with 24 still requesting -> 24 is granted (`select`=25).
- `clear_n` dropped asynchronously mid-grant between edges -> all outputs are 0 immediately. After `clear_n` rises with `req` bit 10 held -> source 10 is granted on the next edge.
